// File: rtl/comm_rx_fifo.sv
// comm_rx_fifo: serial frame receiver for the inter-board link.
// rec_data is sampled on rising edges of the sender's bit clock freq, after
// both have been synchronised into clk2. Good words go into a first-word
// fall-through FIFO with a valid/ready output. en tells the sender that
// there is room for another frame.
// Optional feature: define COMM_RX_PARITY_EN to add a parity bit after the
// data bits. Without it there is no parity bit and parity_err stays 0.
module comm_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 2,
    parameter bit ODD_PARITY = 1'b0,
    parameter int DEPTH      = 4
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic              rec_data,
    input  logic              freq,
    input  logic              rec_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              en,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overflow
);

    localparam int BCW = $clog2(DATA_W + 1);
    localparam int SCW = $clog2(STOP_BITS + 1);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic freq_p0, freq_p1, freq_p2;
    logic rec_data_p0, rec_data_p1;
    logic bit_stb, bit_val, sample;

    state_t            state, state_next;
    logic [BCW-1:0]    bitcnt, bitcnt_next;
    logic [SCW-1:0]    stopcnt, stopcnt_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic              push_req;
    logic              frame_err_next;
    logic              overflow_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [PW-1:0]     count, count_next;
    logic              full, pop, push;

`ifdef COMM_RX_PARITY_EN
    logic par_bad, par_bad_next;
    logic parity_err_next;
`else
    logic unused_odd_parity;
    assign unused_odd_parity = ODD_PARITY;
`endif

    // freq: two-flop synchroniser (p0, p1) plus a history flop (p2) for edge detection
    always_ff @(posedge clk2) begin
        if (rst) begin
            freq_p0 <= 1'b0;
            freq_p1 <= 1'b0;
            freq_p2 <= 1'b0;
        end else begin
            freq_p0 <= freq;
            freq_p1 <= freq_p0;
            freq_p2 <= freq_p1;
        end
    end

    // rec_data: two-flop synchroniser, aligned with freq_p1
    always_ff @(posedge clk2) begin
        rec_data_p0 <= rec_data;
        rec_data_p1 <= rec_data_p0;
    end

    assign bit_stb = freq_p1 & ~freq_p2;
    assign bit_val = rec_data_p1;
    assign sample  = bit_stb & rec_en;

    // Frame FSM next state: walks start/data/(parity)/stop, decides push or error
    always_comb begin
        state_next     = state;
        bitcnt_next    = bitcnt;
        stopcnt_next   = stopcnt;
        shreg_next     = shreg;
        push_req       = 1'b0;
        frame_err_next = 1'b0;
`ifdef COMM_RX_PARITY_EN
        par_bad_next    = par_bad;
        parity_err_next = 1'b0;
`endif
        if (state != IDLE && !rec_en) begin
            // receive disabled mid-frame: silent abort
            state_next = IDLE;
        end else if (sample) begin
            case (state)
                IDLE: begin
                    if (!bit_val) begin
                        shreg_next  = '0;
                        bitcnt_next = '0;
                        state_next  = DATA;
                    end
                end
                DATA: begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (bitcnt == BCW'(i)) shreg_next[i] = bit_val;
                    end
                    bitcnt_next = bitcnt + BCW'(1);
                    if (bitcnt == BCW'(DATA_W - 1)) begin
`ifdef COMM_RX_PARITY_EN
                        state_next = PARITY;
`else
                        stopcnt_next = '0;
                        state_next   = STOP;
`endif
                    end
                end
`ifdef COMM_RX_PARITY_EN
                PARITY: begin
                    par_bad_next = (^shreg) ^ bit_val ^ ODD_PARITY;
                    stopcnt_next = '0;
                    state_next   = STOP;
                end
`endif
                STOP: begin
                    if (bit_val) begin
                        if (stopcnt == SCW'(STOP_BITS - 1)) begin
                            state_next = IDLE;
`ifdef COMM_RX_PARITY_EN
                            if (par_bad) parity_err_next = 1'b1;
                            else         push_req        = 1'b1;
`else
                            push_req = 1'b1;
`endif
                        end else begin
                            stopcnt_next = stopcnt + SCW'(1);
                        end
                    end else begin
                        // a 0 stop bit is never reused as a start bit
                        frame_err_next = 1'b1;
                        state_next     = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Frame FSM control registers and single-cycle error pulses
    always_ff @(posedge clk2) begin
        if (rst) begin
            state     <= IDLE;
            bitcnt    <= '0;
            stopcnt   <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            bitcnt    <= bitcnt_next;
            stopcnt   <= stopcnt_next;
            frame_err <= frame_err_next;
            overflow  <= overflow_next;
        end
    end

`ifdef COMM_RX_PARITY_EN
    // Parity verdict for the current frame and its error pulse
    always_ff @(posedge clk2) begin
        if (rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad    <= par_bad_next;
            parity_err <= parity_err_next;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Shift register holding the data bits of the frame in flight
    always_ff @(posedge clk2) begin
        shreg <= shreg_next;
    end

    // FIFO bookkeeping: extra pointer bit distinguishes full from empty
    assign count         = wr_ptr - rd_ptr;
    assign full          = (count == PW'(DEPTH));
    assign out_valid     = (wr_ptr != rd_ptr);
    assign pop           = out_valid & out_ready;
    assign push          = push_req & (~full | pop);
    assign overflow_next = push_req & full & ~pop;
    assign wr_ptr_next   = wr_ptr + PW'(push);
    assign rd_ptr_next   = rd_ptr + PW'(pop);
    assign count_next    = wr_ptr_next - rd_ptr_next;
    assign out_data      = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

    // FIFO pointers and the registered room-available flag
    always_ff @(posedge clk2) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            en     <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            en     <= (count_next < PW'(DEPTH));
        end
    end

    // FIFO storage write
    always_ff @(posedge clk2) begin
        if (push) mem[wr_ptr[AW-1:0]] <= shreg;
    end

endmodule
